// File: rtl/uop_block_builder.sv
// Drains the uop FIFO in program order, merges sequential instructions into
// retirement blocks and hands each closed block to the trace encoder.
module uop_block_builder #(
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 3,
  parameter int PRIV_LEN    = 2,
  parameter int IRETIRE_LEN = 32,
  parameter int IRETIRE_MAX = 4095
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   uop_valid_i,
  input  logic [XLEN-1:0]        uop_pc_i,
  input  logic [ITYPE_LEN-1:0]   uop_itype_i,
  input  logic                   uop_compressed_i,
  input  logic [PRIV_LEN-1:0]    uop_priv_i,
  output logic                   uop_pop_o,
  input  logic                   flush_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [XLEN-1:0]        blk_iaddr_o,
  output logic [IRETIRE_LEN-1:0] blk_iretire_o,
  output logic                   blk_ilastsize_o,
  output logic [ITYPE_LEN-1:0]   blk_itype_o,
  output logic [PRIV_LEN-1:0]    blk_priv_o
);

  localparam logic [ITYPE_LEN-1:0]   IT_STD  = ITYPE_LEN'(0);
  localparam logic [ITYPE_LEN-1:0]   IT_EXC  = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0]   IT_INT  = ITYPE_LEN'(2);
  localparam logic [IRETIRE_LEN-1:0] MAX_CNT = IRETIRE_LEN'(IRETIRE_MAX);

  typedef enum logic {IDLE, COUNT} state_e;

  state_e                 r_state, w_state_next;
  logic [XLEN-1:0]        r_start, w_start_next;
  logic [IRETIRE_LEN-1:0] r_count, w_count_next;
  logic                   r_last, w_last_next;
  logic [PRIV_LEN-1:0]    r_priv, w_priv_next;

  logic                   r_blk_valid, w_blk_valid_next;
  logic [XLEN-1:0]        r_blk_iaddr, w_blk_iaddr_next;
  logic [IRETIRE_LEN-1:0] r_blk_iretire, w_blk_iretire_next;
  logic                   r_blk_ilastsize, w_blk_ilastsize_next;
  logic [ITYPE_LEN-1:0]   r_blk_itype, w_blk_itype_next;
  logic [PRIV_LEN-1:0]    r_blk_priv, w_blk_priv_next;

  logic                   w_out_free;
  logic                   w_priv_split;
  logic                   w_pop;
  logic                   w_is_std;
  logic                   w_is_trap;
  logic [IRETIRE_LEN-1:0] w_sz;
  logic [IRETIRE_LEN-1:0] w_count_inc;

  assign w_out_free   = !r_blk_valid || blk_ready_i;
  assign w_priv_split = (r_state == COUNT) && uop_valid_i && (uop_priv_i != r_priv);
  assign w_pop        = uop_valid_i && w_out_free && !flush_i && !w_priv_split && !rst_i;
  assign w_is_std     = (uop_itype_i == IT_STD);
  assign w_is_trap    = (uop_itype_i == IT_EXC) || (uop_itype_i == IT_INT);
  assign w_sz         = uop_compressed_i ? IRETIRE_LEN'(1) : IRETIRE_LEN'(2);
  assign w_count_inc  = r_count + w_sz;

  always_comb begin
    w_state_next         = r_state;
    w_start_next         = r_start;
    w_count_next         = r_count;
    w_last_next          = r_last;
    w_priv_next          = r_priv;
    // A free output register either held nothing or is being consumed now.
    w_blk_valid_next     = r_blk_valid && !w_out_free;
    w_blk_iaddr_next     = r_blk_iaddr;
    w_blk_iretire_next   = r_blk_iretire;
    w_blk_ilastsize_next = r_blk_ilastsize;
    w_blk_itype_next     = r_blk_itype;
    w_blk_priv_next      = r_blk_priv;

    if (w_out_free) begin
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            if (w_is_std) begin
              w_state_next = COUNT;
              w_start_next = uop_pc_i;
              w_count_next = w_sz;
              w_last_next  = !uop_compressed_i;
              w_priv_next  = uop_priv_i;
            end else begin
              w_blk_valid_next = 1'b1;
              w_blk_iaddr_next = uop_pc_i;
              w_blk_itype_next = uop_itype_i;
              w_blk_priv_next  = uop_priv_i;
              if (w_is_trap) begin
                w_blk_iretire_next   = '0;
                w_blk_ilastsize_next = 1'b0;
              end else begin
                w_blk_iretire_next   = w_sz;
                w_blk_ilastsize_next = !uop_compressed_i;
              end
            end
          end
        end
        COUNT: begin
          if (flush_i || w_priv_split) begin
            w_blk_valid_next     = 1'b1;
            w_blk_iaddr_next     = r_start;
            w_blk_iretire_next   = r_count;
            w_blk_ilastsize_next = r_last;
            w_blk_itype_next     = IT_STD;
            w_blk_priv_next      = r_priv;
            w_state_next         = IDLE;
          end else if (w_pop) begin
            w_blk_iaddr_next = r_start;
            w_blk_priv_next  = r_priv;
            if (w_is_std) begin
              w_count_next = w_count_inc;
              w_last_next  = !uop_compressed_i;
              if (w_count_inc >= MAX_CNT) begin
                w_blk_valid_next     = 1'b1;
                w_blk_iretire_next   = w_count_inc;
                w_blk_ilastsize_next = !uop_compressed_i;
                w_blk_itype_next     = IT_STD;
                w_state_next         = IDLE;
              end
            end else if (w_is_trap) begin
              // The trapping instruction itself does not retire.
              w_blk_valid_next     = 1'b1;
              w_blk_iretire_next   = r_count;
              w_blk_ilastsize_next = r_last;
              w_blk_itype_next     = uop_itype_i;
              w_state_next         = IDLE;
            end else begin
              w_blk_valid_next     = 1'b1;
              w_blk_iretire_next   = w_count_inc;
              w_blk_ilastsize_next = !uop_compressed_i;
              w_blk_itype_next     = uop_itype_i;
              w_state_next         = IDLE;
            end
          end
        end
        default: w_state_next = IDLE;
      endcase
    end

    if (w_state_next == IDLE && r_state == COUNT) begin
      w_start_next = '0;
      w_count_next = '0;
      w_last_next  = 1'b0;
      w_priv_next  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state         <= IDLE;
      r_start         <= '0;
      r_count         <= '0;
      r_last          <= 1'b0;
      r_priv          <= '0;
      r_blk_valid     <= 1'b0;
      r_blk_iaddr     <= '0;
      r_blk_iretire   <= '0;
      r_blk_ilastsize <= 1'b0;
      r_blk_itype     <= '0;
      r_blk_priv      <= '0;
    end else begin
      r_state         <= w_state_next;
      r_start         <= w_start_next;
      r_count         <= w_count_next;
      r_last          <= w_last_next;
      r_priv          <= w_priv_next;
      r_blk_valid     <= w_blk_valid_next;
      r_blk_iaddr     <= w_blk_iaddr_next;
      r_blk_iretire   <= w_blk_iretire_next;
      r_blk_ilastsize <= w_blk_ilastsize_next;
      r_blk_itype     <= w_blk_itype_next;
      r_blk_priv      <= w_blk_priv_next;
    end
  end

  // Outputs read as zero for the whole time reset is held, not just after the edge.
  assign uop_pop_o       = w_pop;
  assign blk_valid_o     = r_blk_valid && !rst_i;
  assign blk_iaddr_o     = rst_i ? '0 : r_blk_iaddr;
  assign blk_iretire_o   = rst_i ? '0 : r_blk_iretire;
  assign blk_ilastsize_o = r_blk_ilastsize && !rst_i;
  assign blk_itype_o     = rst_i ? '0 : r_blk_itype;
  assign blk_priv_o      = rst_i ? '0 : r_blk_priv;

endmodule

// File: tb/tb_uop_block_builder.sv
// Bench for uop_block_builder: directed scenarios plus a randomized stream,
// checked against a sequence-level block model and a scoreboard.
module tb_uop_block_builder;

  localparam int IMAX = 8;
  localparam logic [2:0] STD = 3'd0, EXC = 3'd1, INT = 3'd2, ERET = 3'd3;
  localparam logic [2:0] NTB = 3'd4, TB = 3'd5, UIJ = 3'd6, RES = 3'd7;

  logic        clk = 1'b0;
  logic        rst_i, uop_valid_i, uop_compressed_i, uop_pop_o, flush_i;
  logic [31:0] uop_pc_i;
  logic [2:0]  uop_itype_i;
  logic [1:0]  uop_priv_i;
  logic        blk_valid_o, blk_ready_i, blk_ilastsize_o;
  logic [31:0] blk_iaddr_o, blk_iretire_o;
  logic [2:0]  blk_itype_o;
  logic [1:0]  blk_priv_o;

  always #5 clk = ~clk;

  uop_block_builder #(
    .XLEN(32), .ITYPE_LEN(3), .PRIV_LEN(2), .IRETIRE_LEN(32), .IRETIRE_MAX(IMAX)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .uop_valid_i(uop_valid_i), .uop_pc_i(uop_pc_i), .uop_itype_i(uop_itype_i),
    .uop_compressed_i(uop_compressed_i), .uop_priv_i(uop_priv_i), .uop_pop_o(uop_pop_o),
    .flush_i(flush_i), .blk_valid_o(blk_valid_o), .blk_ready_i(blk_ready_i),
    .blk_iaddr_o(blk_iaddr_o), .blk_iretire_o(blk_iretire_o),
    .blk_ilastsize_o(blk_ilastsize_o), .blk_itype_o(blk_itype_o), .blk_priv_o(blk_priv_o)
  );

  typedef struct { logic [31:0] pc; logic [2:0] it; logic c; logic [1:0] pr; } ent_t;
  typedef struct { logic [31:0] iaddr; logic [31:0] iret; logic ls; logic [2:0] it; logic [1:0] pr; } blk_t;

  ent_t fifo[$];
  blk_t exp_q[$];
  int   checks = 0, errors = 0, pops = 0, blocks = 0;
  bit   ready_rand = 0, gap_en = 0, prev_stall = 0;
  int   ready_pct = 100;
  logic s_pop, s_valid;
  blk_t s_blk, prev_blk, last_blk;

  // Sequence-level model: open block state in program order, no timing.
  bit          m_open = 0;
  logic [31:0] m_start, m_cnt;
  logic        m_last;
  logic [1:0]  m_pr;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic emit(input logic [31:0] a, input logic [31:0] r, input logic l,
                      input logic [2:0] t, input logic [1:0] p);
    blk_t b;
    b.iaddr = a; b.iret = r; b.ls = l; b.it = t; b.pr = p;
    exp_q.push_back(b);
  endtask

  task automatic model_push(input ent_t e);
    logic [31:0] sz;
    bit trap;
    sz   = e.c ? 32'd1 : 32'd2;
    trap = (e.it == EXC) || (e.it == INT);
    if (m_open && e.pr != m_pr) begin
      emit(m_start, m_cnt, m_last, STD, m_pr);
      m_open = 0;
    end
    if (!m_open) begin
      if (e.it == STD) begin
        m_open = 1; m_start = e.pc; m_cnt = sz; m_last = !e.c; m_pr = e.pr;
      end else if (trap) emit(e.pc, 32'd0, 1'b0, e.it, e.pr);
      else emit(e.pc, sz, !e.c, e.it, e.pr);
    end else if (e.it == STD) begin
      m_cnt  = m_cnt + sz;
      m_last = !e.c;
      if (m_cnt >= IMAX) begin
        emit(m_start, m_cnt, m_last, STD, m_pr);
        m_open = 0;
      end
    end else if (trap) begin
      emit(m_start, m_cnt, m_last, e.it, m_pr);
      m_open = 0;
    end else begin
      emit(m_start, m_cnt + sz, !e.c, e.it, m_pr);
      m_open = 0;
    end
  endtask

  task automatic model_flush();
    if (m_open) begin
      emit(m_start, m_cnt, m_last, STD, m_pr);
      m_open = 0;
    end
  endtask

  task automatic push_entry(input logic [31:0] pc, input logic [2:0] it, input logic c,
                            input logic [1:0] pr);
    ent_t e;
    e.pc = pc; e.it = it; e.c = c; e.pr = pr;
    fifo.push_back(e);
    model_push(e);
  endtask

  // One clock: drive at negedge, sample 1 ns later, retire the pop after posedge.
  task automatic cycle();
    @(negedge clk);
    if (ready_rand) blk_ready_i = ($urandom_range(99) < ready_pct);
    if (fifo.size() > 0 && (!gap_en || $urandom_range(3) != 0)) begin
      uop_valid_i = 1'b1; uop_pc_i = fifo[0].pc; uop_itype_i = fifo[0].it;
      uop_compressed_i = fifo[0].c; uop_priv_i = fifo[0].pr;
    end else begin
      uop_valid_i = 1'b0; uop_pc_i = $urandom; uop_itype_i = 3'($urandom);
      uop_compressed_i = 1'($urandom); uop_priv_i = 2'($urandom);
    end
    #1;
    s_pop = uop_pop_o; s_valid = blk_valid_o;
    s_blk.iaddr = blk_iaddr_o; s_blk.iret = blk_iretire_o; s_blk.ls = blk_ilastsize_o;
    s_blk.it = blk_itype_o; s_blk.pr = blk_priv_o;
    if (prev_stall && !rst_i) begin
      chk("hold_valid", 64'(s_valid), 64'(1));
      chk("hold_addr_ret", {s_blk.iaddr, s_blk.iret}, {prev_blk.iaddr, prev_blk.iret});
      chk("hold_misc", 64'({s_blk.ls, s_blk.it, s_blk.pr}), 64'({prev_blk.ls, prev_blk.it, prev_blk.pr}));
    end
    if (!uop_valid_i || flush_i || rst_i || (s_valid && !blk_ready_i))
      chk("no_pop", 64'(s_pop), 64'(0));
    if (s_valid && blk_ready_i) begin
      blocks++;
      last_blk = s_blk;
      $display("blk accepted: iaddr=0x%08h iretire=%0d ilastsize=%0d itype=%0d priv=%0d",
               s_blk.iaddr, s_blk.iret, s_blk.ls, s_blk.it, s_blk.pr);
      if (exp_q.size() == 0) chk("unexpected_blk", 64'(exp_q.size()), 64'(1));
      else begin
        blk_t e;
        e = exp_q.pop_front();
        chk("blk_iaddr", 64'(s_blk.iaddr), 64'(e.iaddr));
        chk("blk_iretire", 64'(s_blk.iret), 64'(e.iret));
        chk("blk_size_type_priv", 64'({s_blk.ls, s_blk.it, s_blk.pr}), 64'({e.ls, e.it, e.pr}));
      end
    end
    prev_stall = s_valid && !blk_ready_i && !rst_i;
    prev_blk   = s_blk;
    @(posedge clk);
    #1;
    if (s_pop && fifo.size() > 0) begin
      void'(fifo.pop_front());
      pops++;
    end
  endtask

  task automatic drain_fifo(input int budget);
    int n = 0;
    while (fifo.size() > 0 && n < budget) begin cycle(); n++; end
    chk("fifo_drained", 64'(fifo.size()), 64'(0));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((fifo.size() > 0 || exp_q.size() > 0) && n < budget) begin cycle(); n++; end
    chk("all_drained", 64'(fifo.size() + exp_q.size()), 64'(0));
  endtask

  task automatic flush_close();
    drain_fifo(200);
    blk_ready_i = 1'b1;
    flush_i = 1'b1;
    model_flush();
    cycle();
    flush_i = 1'b0;
    drain(200);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc;
    logic [1:0]  pr;
    logic [2:0]  it;
    logic        c;
    rst_i = 1'b1; uop_valid_i = 1'b0; uop_pc_i = '0; uop_itype_i = '0;
    uop_compressed_i = 1'b0; uop_priv_i = '0; flush_i = 1'b0; blk_ready_i = 1'b1;

    // Reset state
    repeat (2) begin
      cycle();
      chk("reset_valid", 64'(s_valid), 64'(0));
      chk("reset_addr_ret", {s_blk.iaddr, s_blk.iret}, 64'(0));
    end
    rst_i = 1'b0;

    // Sequential merge closed by a taken branch, latency of one cycle
    push_entry(32'h100, STD, 1'b0, 2'd0);
    push_entry(32'h104, STD, 1'b1, 2'd0);
    push_entry(32'h106, TB,  1'b0, 2'd0);
    repeat (3) begin
      cycle();
      chk("t1_pop", 64'(s_pop), 64'(1));
      chk("t1_no_early_valid", 64'(s_valid), 64'(0));
    end
    cycle();
    chk("t1_latency", 64'(s_valid), 64'(1));
    chk("t1_blk_addr_ret", {last_blk.iaddr, last_blk.iret}, {32'h100, 32'd5});
    chk("t1_blk_size_type", 64'({last_blk.ls, last_blk.it}), 64'({1'b1, TB}));
    chk("t1_pops", 64'(pops), 64'(3));
    drain(50);

    // Exception mid-block, then a lone exception in IDLE
    push_entry(32'h200, STD, 1'b0, 2'd0);
    push_entry(32'h204, STD, 1'b0, 2'd0);
    push_entry(32'h208, EXC, 1'b0, 2'd0);
    push_entry(32'h400, EXC, 1'b1, 2'd0);
    drain(50);
    chk("t2_lone_exc", {last_blk.iaddr, last_blk.iret}, {32'h400, 32'd0});

    // Privilege change splits the block without popping
    push_entry(32'h300, STD, 1'b0, 2'd3);
    push_entry(32'h304, STD, 1'b0, 2'd0);
    cycle(); chk("t3_pop_first", 64'(s_pop), 64'(1));
    cycle(); chk("t3_split_nopop", 64'(s_pop), 64'(0));
    cycle(); chk("t3_pop_second", 64'(s_pop), 64'(1));
    chk("t3_split_blk", 64'({last_blk.it, last_blk.pr}), 64'({STD, 2'd3}));
    flush_close();

    // Backpressure: outputs hold, nothing pops, then no bubble
    blk_ready_i = 1'b0;
    push_entry(32'h500, TB, 1'b0, 2'd1);
    push_entry(32'h510, TB, 1'b0, 2'd1);
    push_entry(32'h520, TB, 1'b0, 2'd1);
    cycle(); chk("t4_first_pop", 64'(s_pop), 64'(1));
    repeat (5) begin
      cycle();
      chk("t4_stall_nopop", 64'(s_pop), 64'(0));
      chk("t4_stall_valid", 64'(s_valid), 64'(1));
    end
    blk_ready_i = 1'b1;
    cycle(); chk("t4_reload_pop", 64'(s_pop), 64'(1));
    cycle(); chk("t4_nobubble", 64'(s_valid), 64'(1));
    drain(50);

    // Forced close at IRETIRE_MAX
    for (int i = 0; i < 5; i++) push_entry(32'h600 + 32'(4 * i), STD, 1'b0, 2'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("t5_pop", 64'(s_pop), 64'(1));
    end
    chk("t5_overflow_valid", 64'(s_valid), 64'(1));
    chk("t5_overflow_blk", 64'({last_blk.iret, 1'b0, last_blk.it}), 64'({32'd8, 1'b0, STD}));
    flush_close();

    // Flush with an entry waiting: flush wins, entry stays
    for (int i = 0; i < 3; i++) push_entry(32'h700 + 32'(4 * i), STD, 1'b0, 2'd2);
    drain_fifo(50);
    flush_i = 1'b1;
    model_flush();
    push_entry(32'h800, TB, 1'b0, 2'd2);
    cycle(); chk("t6_flush_nopop", 64'(s_pop), 64'(0));
    flush_i = 1'b0;
    cycle();
    chk("t6_flush_valid", 64'(s_valid), 64'(1));
    chk("t6_flush_blk", 64'({last_blk.iret, 1'b0, last_blk.it}), 64'({32'd6, 1'b0, STD}));
    drain(50);

    // Reset while COUNT discards the open block
    push_entry(32'h900, STD, 1'b0, 2'd0);
    push_entry(32'h904, STD, 1'b0, 2'd0);
    drain_fifo(50);
    m_open = 0;
    exp_q.delete();
    push_entry(32'hA00, TB, 1'b1, 2'd1);
    rst_i = 1'b1;
    repeat (2) begin
      cycle();
      chk("t7_rst_pop", 64'(s_pop), 64'(0));
      chk("t7_rst_outs_a", {s_blk.iaddr, s_blk.iret}, 64'(0));
      chk("t7_rst_outs_b", 64'({s_valid, s_blk.ls, s_blk.it, s_blk.pr}), 64'(0));
    end
    rst_i = 1'b0;
    drain(50);
    chk("t7_post_reset_blk", {last_blk.iaddr, last_blk.iret}, {32'hA00, 32'd1});

    // Randomized stream with random backpressure and FIFO gaps
    ready_rand = 1; ready_pct = 70; gap_en = 1;
    pc = 32'h1000_0000; pr = 2'd0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(9) == 0) pr = 2'($urandom);
      it = ($urandom_range(99) < 60) ? STD : 3'($urandom_range(7, 1));
      c  = 1'($urandom_range(1));
      push_entry(pc, it, c, pr);
      if (it == STD) pc = pc + (c ? 32'd2 : 32'd4);
      else pc = $urandom & 32'hFFFF_FFFE;
    end
    push_entry(pc, NTB, 1'b0, pr);
    drain(5000);
    ready_rand = 0; gap_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
